// File: rtl/clock_divider_pkg.sv
// rtl/clock_divider_pkg.sv - shared types and constants for the multi-channel clock divider
package clock_divider_pkg;

  localparam int DIV_W_DEFAULT = 4;

  typedef logic [DIV_W_DEFAULT-1:0] ratio_t;

  // Ratio 0 parks a channel; ratio 1 degenerates to a tick on every enabled cycle.
  localparam ratio_t RATIO_OFF    = ratio_t'(0);
  localparam ratio_t RATIO_BYPASS = ratio_t'(1);

endpackage

// File: rtl/clock_divider_ch.sv
// rtl/clock_divider_ch.sv - one divider channel: counter, active/pending ratio, registered outputs
module clock_divider_ch
  import clock_divider_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk_ext,
  input  logic             rst,
  input  logic [DIV_W-1:0] ratio_i,
  input  logic             cfg_load_i,
  input  logic             en_i,
  input  logic             align_i,
  output logic             clk_div_o,
  output logic             tick_o,
  output logic             pending_o
);

  localparam logic [DIV_W-1:0] R_OFF    = DIV_W'(RATIO_OFF);
  localparam logic [DIV_W-1:0] R_BYPASS = DIV_W'(RATIO_BYPASS);

  logic [DIV_W-1:0] active_q, active_d;
  logic [DIV_W-1:0] pend_ratio_q, pend_ratio_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             en_q;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             slow;
  logic             wrap;
  logic             apply;

  always_comb begin
    slow  = (active_q > R_BYPASS);
    wrap  = slow && (cnt_q == (active_q - R_BYPASS));
    // A new ratio may only land where no partial period would be cut short.
    apply = pend_q && (!en_i || !slow || align_i || wrap);

    active_d     = apply ? pend_ratio_q : active_q;
    pend_ratio_d = cfg_load_i ? ratio_i : pend_ratio_q;
    pend_d       = cfg_load_i ? 1'b1 : (apply ? 1'b0 : pend_q);

    if (!en_i || !en_q || align_i || apply || !slow || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + R_BYPASS;
    end

    // Outputs are computed from next-state values so they line up with cnt_q.
    clk_div_d = en_i && (active_d > R_BYPASS) && (cnt_d < (active_d >> 1));
    tick_d    = en_i && (active_d != R_OFF) && (cnt_d == '0);
  end

  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      active_q     <= '0;
      pend_ratio_q <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      en_q         <= 1'b0;
      clk_div_q    <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      active_q     <= active_d;
      pend_ratio_q <= pend_ratio_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      en_q         <= en_i;
      clk_div_q    <= clk_div_d;
      tick_q       <= tick_d;
    end
  end

  assign clk_div_o = clk_div_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/clock_divider_mc.sv
// rtl/clock_divider_mc.sv - multi-channel programmable clock divider with glitch-free ratio updates
module clock_divider_mc
  import clock_divider_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = DIV_W_DEFAULT
) (
  input  logic                    clk_ext,
  input  logic                    rst,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic                    cfg_load,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    align,
  output logic [NUM_CH-1:0]       clk_div_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       cfg_pending
);

  // cfg_load and align are shared so every channel sees the same boundary.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clock_divider_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk_ext   (clk_ext),
      .rst       (rst),
      .ratio_i   (div_ratio[c*DIV_W +: DIV_W]),
      .cfg_load_i(cfg_load),
      .en_i      (ch_en[c]),
      .align_i   (align),
      .clk_div_o (clk_div_out[c]),
      .tick_o    (tick[c]),
      .pending_o (cfg_pending[c])
    );
  end

endmodule
